// File: rtl/bspi_ctl.sv
// SPI register-access sequencer: turns the slave's per-frame byte stream into a
// command byte plus auto-incrementing register-bus reads/writes with read prefetch.
module bspi_ctl #(
  parameter int unsigned TMO = 255
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       frm,
  input  logic       bwv,
  input  logic [7:0] bdt,
  input  logic       brd,
  output logic       wfl,
  output logic [7:0] rdt,
  output logic       rey,
  output logic       bus_req,
  output logic       bus_we,
  output logic [6:0] bus_adr,
  output logic [7:0] bus_wdt,
  input  logic [7:0] bus_rdt,
  input  logic       bus_ack,
  output logic [1:0] err,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR_WAIT,
    WR_BUS,
    RD_BUS,
    RD_HOLD,
    DRAIN
  } state_t;

  state_t     state;
  logic       frm_q;
  logic [6:0] adr;
  logic [9:0] cnt;
  logic       tmo_hit;
  logic       done;

  // A timeout completes the transaction exactly like an ack would.
  assign tmo_hit = bus_req && !bus_ack && (cnt == 10'(TMO - 1));
  assign done    = bus_req && (bus_ack || tmo_hit);

  assign wfl  = (state == WR_BUS);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      frm_q   <= 1'b0;
      adr     <= '0;
      cnt     <= '0;
      rdt     <= '0;
      rey     <= 1'b1;
      bus_req <= 1'b0;
      bus_we  <= 1'b0;
      bus_adr <= '0;
      bus_wdt <= '0;
      err     <= '0;
    end else begin
      frm_q <= frm;
      cnt   <= (bus_req && !done) ? cnt + 10'd1 : '0;

      if (state == IDLE) begin
        if (frm && !frm_q) begin
          err   <= '0;
          state <= CMD;
        end
      end else if (state == DRAIN) begin
        // Outstanding transaction finishes; its read data is discarded.
        if (done) begin
          bus_req <= 1'b0;
          rey     <= 1'b1;
          state   <= IDLE;
          if (tmo_hit) err[1] <= 1'b1;
        end
      end else if (!frm) begin
        rey <= 1'b1;
        if (bus_req && !done) begin
          state <= DRAIN;
        end else begin
          bus_req <= 1'b0;
          state   <= IDLE;
          if (tmo_hit) err[1] <= 1'b1;
        end
      end else begin
        case (state)
          CMD: begin
            if (bwv) begin
              adr <= bdt[6:0];
              if (bdt[7]) begin
                bus_req <= 1'b1;
                bus_we  <= 1'b0;
                bus_adr <= bdt[6:0];
                state   <= RD_BUS;
              end else begin
                state <= WR_WAIT;
              end
            end
          end
          WR_WAIT: begin
            if (bwv) begin
              bus_wdt <= bdt;
              bus_adr <= adr;
              bus_we  <= 1'b1;
              bus_req <= 1'b1;
              state   <= WR_BUS;
            end
          end
          WR_BUS: begin
            if (bwv) err[0] <= 1'b1;
            if (done) begin
              bus_req <= 1'b0;
              adr     <= adr + 7'd1;
              state   <= WR_WAIT;
              if (tmo_hit) err[1] <= 1'b1;
            end
          end
          RD_BUS: begin
            if (brd && rey) err[0] <= 1'b1;
            if (done) begin
              bus_req <= 1'b0;
              rdt     <= tmo_hit ? 8'hFF : bus_rdt;
              rey     <= 1'b0;
              adr     <= adr + 7'd1;
              state   <= RD_HOLD;
              if (tmo_hit) err[1] <= 1'b1;
            end
          end
          RD_HOLD: begin
            if (brd) begin
              rey     <= 1'b1;
              bus_req <= 1'b1;
              bus_adr <= adr;
              state   <= RD_BUS;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
